// File: rtl/prbs_pam_symbol_tx.sv
// PRBS9 burst source mapped to PAM2/PAM4 and zero-stuffed to OS samples/symbol; registered outputs, first sample one edge after start.
// Backpressure: i_en=0 freezes the generator and drops o_valid while o_sample holds.
module prbs_pam_symbol_tx #(
    parameter int         NB_OUT  = 18,
    parameter int         NBF_OUT = 15,
    parameter int         OS      = 4,
    parameter int         N_SYM   = 1024,
    parameter logic [8:0] SEED    = 9'h1FF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_mode,
    input  logic                     i_en,
    output logic signed [NB_OUT-1:0] o_sample,
    output logic                     o_valid,
    output logic                     o_done,
    output logic                     o_busy
);

    localparam int PW = (OS > 1) ? $clog2(OS) : 1;
    localparam int SW = (N_SYM > 1) ? $clog2(N_SYM) : 1;
    localparam int U  = 1 << NBF_OUT;

    localparam logic signed [NB_OUT-1:0] LVL_P1  = NB_OUT'(U);
    localparam logic signed [NB_OUT-1:0] LVL_M1  = NB_OUT'(-U);
    localparam logic signed [NB_OUT-1:0] LVL_P34 = NB_OUT'(3 * U / 4);
    localparam logic signed [NB_OUT-1:0] LVL_M34 = NB_OUT'(-(3 * U / 4));
    localparam logic signed [NB_OUT-1:0] LVL_P14 = NB_OUT'(U / 4);
    localparam logic signed [NB_OUT-1:0] LVL_M14 = NB_OUT'(-(U / 4));

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state, state_nxt;
    logic [8:0]                lfsr, lfsr_nxt, s1, s2;
    logic [PW-1:0]             phase, phase_nxt;
    logic [SW-1:0]             sym_cnt, sym_nxt;
    logic                      mode, mode_nxt;
    logic                      b1, b2;
    logic signed [NB_OUT-1:0]  level, sample_nxt;
    logic                      valid_nxt;

    // Two LFSR steps per cycle are available; PAM4 uses both, first bit is the MSB.
    always_comb begin
        b1 = lfsr[8] ^ lfsr[4];
        s1 = {lfsr[7:0], b1};
        b2 = s1[8] ^ s1[4];
        s2 = {s1[7:0], b2};
        level = b1 ? LVL_P1 : LVL_M1;
        if (mode) begin
            case ({b1, b2})
                2'b00:   level = LVL_M34;
                2'b01:   level = LVL_M14;
                2'b11:   level = LVL_P14;
                default: level = LVL_P34;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        lfsr_nxt   = lfsr;
        phase_nxt  = phase;
        sym_nxt    = sym_cnt;
        mode_nxt   = mode;
        sample_nxt = o_sample;
        valid_nxt  = 1'b0;
        case (state)
            IDLE, DONE: begin
                sample_nxt = '0;
                if (i_start) begin
                    state_nxt = RUN;
                    lfsr_nxt  = SEED;
                    phase_nxt = '0;
                    sym_nxt   = '0;
                    mode_nxt  = i_mode;
                end
            end
            RUN: begin
                if (i_en) begin
                    valid_nxt  = 1'b1;
                    sample_nxt = (phase == '0) ? level : '0;
                    if (phase == '0)
                        lfsr_nxt = mode ? s2 : s1;
                    if (phase == PW'(OS - 1)) begin
                        phase_nxt = '0;
                        if (sym_cnt == SW'(N_SYM - 1))
                            state_nxt = DONE;
                        else
                            sym_nxt = sym_cnt + SW'(1);
                    end else begin
                        phase_nxt = phase + PW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            lfsr     <= SEED;
            phase    <= '0;
            sym_cnt  <= '0;
            mode     <= 1'b0;
            o_sample <= '0;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            phase    <= phase_nxt;
            sym_cnt  <= sym_nxt;
            mode     <= mode_nxt;
            o_sample <= sample_nxt;
            o_valid  <= valid_nxt;
            o_done   <= (state_nxt == DONE);
            o_busy   <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_prbs_pam_symbol_tx.sv
// Directed bench for prbs_pam_symbol_tx: three instances (OS=1/N=8, OS=4/N=8, OS=1/N=1022)
// driven and sampled on the falling clock edge.
module tb_prbs_pam_symbol_tx;

    logic clk = 1'b0;
    logic rst;
    logic mode;
    logic start_a, start_b, start_c;
    logic en_a, en_b, en_c;
    logic signed [17:0] samp_a, samp_b, samp_c;
    logic vld_a, vld_b, vld_c, done_a, done_b, done_c, busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    prbs_pam_symbol_tx #(.NB_OUT(18), .NBF_OUT(15), .OS(1), .N_SYM(8), .SEED(9'h1FF)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_mode(mode), .i_en(en_a),
        .o_sample(samp_a), .o_valid(vld_a), .o_done(done_a), .o_busy(busy_a));
    prbs_pam_symbol_tx #(.NB_OUT(18), .NBF_OUT(15), .OS(4), .N_SYM(8), .SEED(9'h1FF)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_mode(mode), .i_en(en_b),
        .o_sample(samp_b), .o_valid(vld_b), .o_done(done_b), .o_busy(busy_b));
    prbs_pam_symbol_tx #(.NB_OUT(18), .NBF_OUT(15), .OS(1), .N_SYM(1022), .SEED(9'h1FF)) dut_c (
        .clk(clk), .rst(rst), .i_start(start_c), .i_mode(mode), .i_en(en_c),
        .o_sample(samp_c), .o_valid(vld_c), .o_done(done_c), .o_busy(busy_c));

    typedef struct {
        int idx;
        int exp;
    } vec_t;

    vec_t tab_a[8];
    vec_t tab_b[15];
    int   checks = 0;
    int   errors = 0;
    int   qa[$], qa_ref[$], qb[$], qc[$], exp_q[$];
    int   busy0, first_vld, vld_at_done, busy_at_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int q_diff(input int a[$], input int b[$]);
        int n;
        n = (a.size() == b.size()) ? 0 : 1;
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] != b[i]) n++;
        return n;
    endfunction

    // Reference stream from the PRBS9 recurrence and the level table at default widths.
    task automatic build_exp(input bit pam4, input int os, input int nsym);
        logic [8:0] s;
        logic       b1, b2;
        int         lvl;
        s = 9'h1FF;
        exp_q.delete();
        for (int k = 0; k < nsym; k++) begin
            b1 = s[8] ^ s[4];
            s  = {s[7:0], b1};
            if (pam4) begin
                b2 = s[8] ^ s[4];
                s  = {s[7:0], b2};
                case ({b1, b2})
                    2'b00:   lvl = -24576;
                    2'b01:   lvl = -8192;
                    2'b11:   lvl = 8192;
                    default: lvl = 24576;
                endcase
            end else begin
                lvl = b1 ? 32768 : -32768;
            end
            exp_q.push_back(lvl);
            for (int z = 1; z < os; z++) exp_q.push_back(0);
        end
    endtask

    task automatic collect_a(input int budget);
        qa.delete();
        first_vld = -1;
        busy0 = 0;
        vld_at_done = 0;
        busy_at_done = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (i == 0) busy0 = int'(busy_a);
            if (vld_a) begin
                if (first_vld < 0) first_vld = i;
                qa.push_back(int'(samp_a));
            end
            if (done_a) begin
                vld_at_done = int'(vld_a);
                busy_at_done = int'(busy_a);
                break;
            end
        end
    endtask

    initial begin
        int hold_err, zero_err, per_err, last;

        tab_a[0] = '{0, -32768}; tab_a[1] = '{1, -32768}; tab_a[2] = '{2, -32768};
        tab_a[3] = '{3, -32768}; tab_a[4] = '{4, -32768}; tab_a[5] = '{5, 32768};
        tab_a[6] = '{6, 32768};  tab_a[7] = '{7, 32768};
        tab_b[0]  = '{0, -24576}; tab_b[1]  = '{1, 0};  tab_b[2]  = '{2, 0};  tab_b[3] = '{3, 0};
        tab_b[4]  = '{4, -24576}; tab_b[5]  = '{5, 0};  tab_b[6]  = '{6, 0};  tab_b[7] = '{7, 0};
        tab_b[8]  = '{8, -8192};  tab_b[9]  = '{9, 0};  tab_b[10] = '{10, 0}; tab_b[11] = '{11, 0};
        tab_b[12] = '{12, 8192};  tab_b[13] = '{16, 24576}; tab_b[14] = '{20, 8192};

        // Reset held with start asserted: nothing may leave IDLE.
        rst = 1'b0; mode = 1'b0;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sample", int'(samp_a), 0);
        chk("rst_valid", int'(vld_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", int'(busy_a), 0);

        // PAM2 OS=1 burst of 8.
        mode = 1'b0; start_a = 1'b1;
        collect_a(40);
        chk("a_busy_after_start", busy0, 1);
        chk("a_first_valid_cycle", first_vld, 1);
        chk("a_count", qa.size(), 8);
        foreach (tab_a[i])
            chk($sformatf("a_sample_%0d", tab_a[i].idx),
                (tab_a[i].idx < qa.size()) ? qa[tab_a[i].idx] : -1, tab_a[i].exp);
        chk("a_done_with_last", vld_at_done, 1);
        chk("a_busy_at_done", busy_at_done, 0);
        qa_ref = qa;

        // Start raised in DONE: one gap cycle, identical second burst.
        start_a = 1'b1;
        @(negedge clk);
        chk("a_gap_valid", int'(vld_a), 0);
        chk("a_gap_busy", int'(busy_a), 1);
        collect_a(40);
        chk("a_restart_first_valid", first_vld, 0);
        chk("a_restart_identical", q_diff(qa, qa_ref), 0);

        // PAM4 OS=4 unstalled.
        mode = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; mode = 1'b0;
        qb.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (vld_b) qb.push_back(int'(samp_b));
            if (done_b) break;
        end
        chk("b_count", qb.size(), 32);
        foreach (tab_b[i])
            chk($sformatf("b_sample_%0d", tab_b[i].idx),
                (tab_b[i].idx < qb.size()) ? qb[tab_b[i].idx] : -1, tab_b[i].exp);
        zero_err = 0;
        foreach (qb[i]) if ((i % 4) != 0 && qb[i] != 0) zero_err++;
        chk("b_zero_stuffing", zero_err, 0);
        build_exp(1'b1, 4, 8);
        chk("b_pam4_stream", q_diff(qb, exp_q), 0);
        @(negedge clk);
        chk("b_done_level", int'(done_b), 1);
        chk("b_valid_in_done", int'(vld_b), 0);
        chk("b_sample_in_done", int'(samp_b), 0);
        @(negedge clk);
        chk("b_done_held", int'(done_b), 1);

        // PAM2 OS=4 with random stalls, mode/start toggled during RUN.
        mode = 1'b0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        qb.delete();
        hold_err = 0;
        last = int'(samp_b);
        for (int i = 0; i < 600; i++) begin
            en_b    = 1'($urandom_range(0, 1));
            mode    = 1'($urandom_range(0, 1));
            start_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (vld_b) qb.push_back(int'(samp_b));
            else if (int'(samp_b) != last) hold_err++;
            last = int'(samp_b);
            if (done_b) break;
        end
        start_b = 1'b0; en_b = 1'b1; mode = 1'b0;
        chk("b_stall_done_reached", int'(done_b), 1);
        chk("b_stall_count", qb.size(), 32);
        chk("b_stall_hold", hold_err, 0);
        build_exp(1'b0, 4, 8);
        chk("b_stall_stream", q_diff(qb, exp_q), 0);

        // PAM2 OS=1 over two PRBS periods.
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        qc.delete();
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (vld_c) qc.push_back(int'(samp_c));
            if (done_c) break;
        end
        chk("c_count", qc.size(), 1022);
        chk("c_busy_at_done", int'(busy_c), 0);
        build_exp(1'b0, 1, 1022);
        chk("c_stream", q_diff(qc, exp_q), 0);
        per_err = 0;
        for (int i = 0; i < 511 && i + 511 < qc.size(); i++)
            if (qc[i + 511] != qc[i]) per_err++;
        chk("c_period_511", per_err, 0);

        // Reset mid-burst, start held through reset, then a fresh burst from SEED.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_midburst_valid", int'(vld_a), 1);
        rst = 1'b0; start_a = 1'b1;
        @(negedge clk);
        chk("abort_valid", int'(vld_a), 0);
        chk("abort_sample", int'(samp_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        @(negedge clk);
        chk("abort_start_ignored", int'(busy_a), 0);
        rst = 1'b1;
        collect_a(40);
        chk("abort_restart_first_valid", first_vld, 1);
        chk("abort_restart_seed", q_diff(qa, qa_ref), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
